// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
// The slave modport is the decode stage. The master modport is the fetch/execute environment.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [5:0]      out_op;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [4:0]      out_rd;
   logic            out_rs1_en;
   logic            out_rs2_en;
   logic            out_rd_we;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;

   // A transfer happens on a rising edge where valid and ready are both high.
   // A producer holds valid and its data stable until that edge.
   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_op, out_imm, out_rs1, out_rs2, out_rd,
             out_rs1_en, out_rs2_en, out_rd_we, out_pc, out_illegal
   );
   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_op, out_imm, out_rs1, out_rs2, out_rd,
             out_rs1_en, out_rs2_en, out_rd_we, out_pc, out_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: a DEPTH-entry instruction queue feeds a registered decode slot.
// Defining DECODE_RV32M_EN adds decoding of the M-extension multiply and divide instructions.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   decode_stage_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [5:0] OP_ILL = 6'h3F;
   localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
                          IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

   logic [31:0]     r_q_instr [DEPTH];
   logic [XLEN-1:0] r_q_pc    [DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count;

   logic            r_out_valid, r_out_rs1_en, r_out_rs2_en, r_out_rd_we, r_out_illegal;
   logic [5:0]      r_out_op;
   logic [XLEN-1:0] r_out_imm, r_out_pc;
   logic [4:0]      r_out_rs1, r_out_rs2, r_out_rd;

   logic            w_push, w_load;
   logic [31:0]     w_instr, w_imm32;
   logic [6:0]      w_opc, w_f7;
   logic [2:0]      w_f3, w_imm_sel;
   logic [5:0]      w_op;
   logic            w_rs1_en, w_rs2_en, w_rd_en, w_illegal;

   assign bus.in_ready = (r_count != CW'(DEPTH));
   assign w_push = bus.in_valid & bus.in_ready & ~bus.flush;
   assign w_load = (r_count != '0) & (~r_out_valid | bus.out_ready) & ~bus.flush;

   assign w_instr = r_q_instr[r_rptr];
   assign w_opc   = w_instr[6:0];
   assign w_f3    = w_instr[14:12];
   assign w_f7    = w_instr[31:25];

   // Each opcode group sets its operand enables up front; anything left at OP_ILL is squashed below.
   always_comb begin
      w_op = OP_ILL;
      w_imm_sel = IMM_NONE;
      w_rs1_en = 1'b0;
      w_rs2_en = 1'b0;
      w_rd_en = 1'b0;
      case (w_opc)
         7'b0110011: begin
            {w_rs1_en, w_rs2_en, w_rd_en} = 3'b111;
            if (w_f7 == 7'b0000000) begin
               case (w_f3)
                  3'd0: w_op = 6'h00;
                  3'd1: w_op = 6'h05;
                  3'd2: w_op = 6'h08;
                  3'd3: w_op = 6'h09;
                  3'd4: w_op = 6'h02;
                  3'd5: w_op = 6'h06;
                  3'd6: w_op = 6'h03;
                  default: w_op = 6'h04;
               endcase
            end else if (w_f7 == 7'b0100000 && w_f3 == 3'd0) w_op = 6'h01;
            else if (w_f7 == 7'b0100000 && w_f3 == 3'd5) w_op = 6'h07;
`ifdef DECODE_RV32M_EN
            else if (w_f7 == 7'b0000001) w_op = 6'h28 + {3'b000, w_f3};
`endif
         end
         7'b0010011: begin
            {w_rs1_en, w_rd_en} = 2'b11;
            w_imm_sel = IMM_I;
            case (w_f3)
               3'd0: w_op = 6'h0A;
               3'd1: if (w_f7 == 7'b0000000) w_op = 6'h0E;
               3'd2: w_op = 6'h11;
               3'd3: w_op = 6'h12;
               3'd4: w_op = 6'h0B;
               3'd5: begin
                  if (w_f7 == 7'b0000000) w_op = 6'h0F;
                  else if (w_f7 == 7'b0100000) w_op = 6'h10;
               end
               3'd6: w_op = 6'h0C;
               default: w_op = 6'h0D;
            endcase
         end
         7'b0000011: begin
            {w_rs1_en, w_rd_en} = 2'b11;
            w_imm_sel = IMM_I;
            case (w_f3)
               3'd0: w_op = 6'h13;
               3'd1: w_op = 6'h14;
               3'd2: w_op = 6'h15;
               3'd4: w_op = 6'h16;
               3'd5: w_op = 6'h17;
               default: w_op = OP_ILL;
            endcase
         end
         7'b0100011: begin
            {w_rs1_en, w_rs2_en} = 2'b11;
            w_imm_sel = IMM_S;
            case (w_f3)
               3'd0: w_op = 6'h18;
               3'd1: w_op = 6'h19;
               3'd2: w_op = 6'h1A;
               default: w_op = OP_ILL;
            endcase
         end
         7'b1100011: begin
            {w_rs1_en, w_rs2_en} = 2'b11;
            w_imm_sel = IMM_B;
            case (w_f3)
               3'd0: w_op = 6'h1B;
               3'd1: w_op = 6'h1C;
               3'd4: w_op = 6'h1D;
               3'd5: w_op = 6'h20;
               3'd6: w_op = 6'h24;
               3'd7: w_op = 6'h25;
               default: w_op = OP_ILL;
            endcase
         end
         7'b1101111: begin w_op = 6'h21; w_rd_en = 1'b1; w_imm_sel = IMM_J; end
         7'b0110111: begin w_op = 6'h22; w_rd_en = 1'b1; w_imm_sel = IMM_U; end
         7'b0010111: begin w_op = 6'h23; w_rd_en = 1'b1; w_imm_sel = IMM_U; end
         7'b1100111: begin
            {w_rs1_en, w_rd_en} = 2'b11;
            w_imm_sel = IMM_I;
            if (w_f3 == 3'd0) w_op = 6'h26;
         end
         default: w_op = OP_ILL;
      endcase
      w_illegal = (w_op == OP_ILL);
      if (w_illegal) begin
         {w_rs1_en, w_rs2_en, w_rd_en} = 3'b000;
         w_imm_sel = IMM_NONE;
      end
   end

   always_comb begin
      case (w_imm_sel)
         IMM_I:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
         IMM_S:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         IMM_B:   w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                             w_instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {w_instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                             w_instr[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_instr[r_wptr] <= bus.in_instr;
         r_q_pc[r_wptr]    <= bus.in_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (bus.flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_load) r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_load})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Flush only clears out_valid; the slot payload is dont-care while invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_op      <= OP_ILL;
         r_out_imm     <= '0;
         r_out_rs1     <= '0;
         r_out_rs2     <= '0;
         r_out_rd      <= '0;
         r_out_rs1_en  <= 1'b0;
         r_out_rs2_en  <= 1'b0;
         r_out_rd_we   <= 1'b0;
         r_out_pc      <= '0;
         r_out_illegal <= 1'b0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid   <= 1'b1;
         r_out_op      <= w_op;
         r_out_imm     <= XLEN'($signed(w_imm32));
         r_out_rs1     <= w_rs1_en ? w_instr[19:15] : 5'd0;
         r_out_rs2     <= w_rs2_en ? w_instr[24:20] : 5'd0;
         r_out_rd      <= w_rd_en ? w_instr[11:7] : 5'd0;
         r_out_rs1_en  <= w_rs1_en;
         r_out_rs2_en  <= w_rs2_en;
         r_out_rd_we   <= w_rd_en & (w_instr[11:7] != 5'd0);
         r_out_pc      <= r_q_pc[r_rptr];
         r_out_illegal <= w_illegal;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_valid   = r_out_valid;
   assign bus.out_op      = r_out_op;
   assign bus.out_imm     = r_out_imm;
   assign bus.out_rs1     = r_out_rs1;
   assign bus.out_rs2     = r_out_rs2;
   assign bus.out_rd      = r_out_rd;
   assign bus.out_rs1_en  = r_out_rs1_en;
   assign bus.out_rs2_en  = r_out_rs2_en;
   assign bus.out_rd_we   = r_out_rd_we;
   assign bus.out_pc      = r_out_pc;
   assign bus.out_illegal = r_out_illegal;
endmodule
